// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: detects the host start pulse on the shared
// 1-Wire line, answers with the response preamble, then shifts out a 40-bit
// frame (humidity, temperature, checksum) as DHT11-timed low/high pulses.
module dht11_responder #(
  parameter int unsigned CLKS_PER_US   = 12,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       data_in,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       data_oe,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = 24;

  // Phase loads are N*CLKS_PER_US-1 because the phase ends on the cycle the count reaches zero.
  localparam logic [CW-1:0] START_CYC = CW'(START_MIN_US * CLKS_PER_US);
  localparam logic [CW-1:0] DLY_LOAD  = CW'(RESP_DELAY_US * CLKS_PER_US - 1);
  localparam logic [CW-1:0] RESP_LOAD = CW'(80 * CLKS_PER_US - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(50 * CLKS_PER_US - 1);
  localparam logic [CW-1:0] ZERO_LOAD = CW'(26 * CLKS_PER_US - 1);
  localparam logic [CW-1:0] ONE_LOAD  = CW'(70 * CLKS_PER_US - 1);

  typedef enum logic [2:0] {
    IDLE, START_LOW, WAIT_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          ds;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0]    idx, idx_n;
  logic [39:0]   frame, frame_n;
  logic [7:0]    chk;
  logic          oe_n, busy_n, done_n;

  assign ds = sync[1];

  // Two-flop synchronizer for the asynchronous line level; idles high.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], data_in};
  end

  // State, timer, bit index, frame and registered outputs.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      frame   <= '0;
      data_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      frame   <= frame_n;
      data_oe <= oe_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Next-state, timer and frame logic; outputs are decoded from the next
  // state so the registered outputs track the state register exactly.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    frame_n = frame;
    done_n  = 1'b0;
    chk     = hum_int + hum_dec + temp_int + temp_dec;
    unique case (state)
      IDLE: begin
        if (!ds) begin
          state_n = START_LOW;
          cnt_n   = '0;
        end
      end
      START_LOW: begin
        // The timer counts up here to measure the host low width.
        if (!ds) begin
          if (cnt != '1) cnt_n = cnt + 1'b1;
        end else if (cnt >= START_CYC) begin
          state_n = WAIT_DLY;
          cnt_n   = DLY_LOAD;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      WAIT_DLY: begin
        if (cnt == '0) begin
          state_n = RESP_LOW;
          cnt_n   = RESP_LOAD;
          frame_n = {hum_int, hum_dec, temp_int, temp_dec, chk};
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP_LOW: begin
        if (cnt == '0) begin
          state_n = RESP_HIGH;
          cnt_n   = RESP_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP_HIGH: begin
        if (cnt == '0) begin
          state_n = BIT_LOW;
          cnt_n   = LOW_LOAD;
          idx_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      BIT_LOW: begin
        if (cnt == '0) begin
          state_n = BIT_HIGH;
          cnt_n   = frame[39] ? ONE_LOAD : ZERO_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      BIT_HIGH: begin
        if (cnt == '0) begin
          frame_n = {frame[38:0], 1'b0};
          cnt_n   = LOW_LOAD;
          if (idx == 6'd39) begin
            state_n = END_LOW;
          end else begin
            state_n = BIT_LOW;
            idx_n   = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      END_LOW: begin
        if (cnt == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    oe_n   = (state_n == RESP_LOW) || (state_n == BIT_LOW) || (state_n == END_LOW);
    busy_n = (state_n != IDLE) && (state_n != START_LOW);
  end

endmodule

// File: doc/dht11_responder.md
DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter CLKS_PER_US, default 12, hwclk cycles per microsecond.
REQ-002 Parameter START_MIN_US, default 18000, minimum host start-low width accepted, in µs.
REQ-003 Parameter RESP_DELAY_US, default 30, wait from host release to response, in µs.
REQ-004 hwclk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  1  sampled level of the shared 1-Wire data line (pulled up externally).
REQ-007 hum_int, hum_dec, temp_int, temp_dec  input  8 each  measurement bytes to report.
REQ-008 data_oe  output  1  1 = drive line low (open-drain enable); 0 = release.
REQ-009 busy  output  1  high in every state except IDLE and START_LOW.
REQ-010 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 data_in SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (ds), adding 2 cycles of latency.
REQ-012 Timing SHALL use one down-counter of at least 24 bits; a phase of N µs lasts exactly N*CLKS_PER_US cycles.
REQ-013 States: IDLE, START_LOW, WAIT_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-014 IDLE: data_oe=0; ds=0 -> START_LOW with low-width counter cleared.
REQ-015 START_LOW: count cycles while ds=0; counter saturates, no wrap.
REQ-016 START_LOW, ds=1 with count >= START_MIN_US*CLKS_PER_US -> WAIT_DLY; otherwise -> IDLE, no response (glitch reject).
REQ-017 WAIT_DLY: RESP_DELAY_US, data_oe=0; ds is ignored.
REQ-018 On WAIT_DLY exit: latch the 40-bit frame {hum_int, hum_dec, temp_int, temp_dec, chk}, where chk = (sum of the four bytes) mod 256; later input changes do not affect this frame.
REQ-019 RESP_LOW: 80 µs, data_oe=1.
REQ-020 RESP_HIGH: 80 µs, data_oe=0.
REQ-021 BIT_LOW: 50 µs, data_oe=1.
REQ-022 BIT_HIGH: data_oe=0; 26 µs for bit 0, 70 µs for bit 1.
REQ-023 Bits SHALL be sent MSB first, byte order as in REQ-018; a 6-bit index counts 0..39.
REQ-024 After BIT_HIGH of bit 39 -> END_LOW: 50 µs, data_oe=1; then data_oe=0, done=1 for one cycle, -> IDLE.
REQ-025 ds SHALL be ignored from WAIT_DLY through END_LOW; host activity never aborts a frame.
REQ-026 data_oe SHALL be registered and glitch-free; it changes only at phase boundaries.
REQ-027 A new start low is recognised only after returning to IDLE; back-to-back frames need no idle gap beyond one cycle.

Reset
REQ-028 rst=1 SHALL immediately force data_oe=0, busy=0, done=0, state=IDLE, counters=0, frame register=0.
REQ-029 rst asserted mid-frame SHALL abort at once; after release the block waits in IDLE for a fresh start low.
REQ-030 Synchronizer flops SHALL reset to 1 (line idle high).

Verification
REQ-031 Defaults; host low 20 ms then release; bytes 0x37,0x00,0x18,0x05 -> chk 0x54; data_oe low 80 µs after 30 µs, high 80 µs, then 40 bits decode to 0x3700180554; done pulses once.
REQ-032 Host low 5 ms then release -> data_oe stays 0 and busy stays 0; the next 20 ms low gets a normal response.
REQ-033 Bytes 0xFF,0xFF,0x01,0x02 -> chk 0x01 (wrap); all-ones bytes show 70 µs highs; all-zero bytes 0x00 ×5 show 26 µs highs.
REQ-034 Change hum_int 0x37 -> 0x40 during bit 5 -> the current frame still reports 0x37; the next frame reports 0x40 with recomputed chk.
REQ-035 Assert rst during BIT_HIGH of bit 20 -> data_oe=0 the same cycle, busy=0; after release, a new 20 ms start yields a full, correct frame.
REQ-036 Host pulses the line low during RESP_HIGH and BIT_HIGH -> no effect on timing or data; exactly one done per frame.
